imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: streams words into consecutive addresses,
// optionally pads the tail with a fill word, and gates the core reset around the load.
module imem_loader #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      I_ADDR_W  = 7,
    parameter bit               FILL_EN   = 1'b1,
    parameter logic [WIDTH-1:0] FILL_WORD = '0,
    parameter bit               BOOT_HOLD = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [I_ADDR_W:0]   len,
    input  logic                abort,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                I_wr,
    output logic [I_ADDR_W-1:0] I_addr,
    output logic [WIDTH-1:0]    I_data,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    checksum
);
    localparam int unsigned      CNT_W   = I_ADDR_W + 1;
    localparam int unsigned      DEPTH   = 2 ** I_ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, FINISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] load_len;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_clamped;
    logic             xfer;

    // Only combinational output: abort withdraws ready in the same cycle.
    assign in_ready    = (state == LOAD) && !abort;
    assign xfer        = in_valid && in_ready;
    assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            load_len  <= '0;
            count     <= '0;
            I_wr      <= 1'b0;
            I_addr    <= '0;
            I_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
            cpu_reset <= BOOT_HOLD;
        end else begin
            I_wr <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_len  <= len_clamped;
                        count     <= '0;
                        I_addr    <= '0;
                        checksum  <= '0;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                        if (len_clamped != '0) begin
                            state <= LOAD;
                        end else if (FILL_EN) begin
                            state <= FILL;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                LOAD: begin
                    // Abort beats a coincident transfer; cpu_reset stays asserted.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        I_wr     <= 1'b1;
                        I_addr   <= count[I_ADDR_W-1:0];
                        I_data   <= in_data;
                        checksum <= checksum + in_data;
                        count    <= count + ONE_C;
                        if (count == load_len - ONE_C) begin
                            if (FILL_EN && (load_len != DEPTH_C)) begin
                                state <= FILL;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        I_wr   <= 1'b1;
                        I_addr <= count[I_ADDR_W-1:0];
                        I_data <= FILL_WORD;
                        count  <= count + ONE_C;
                        if (count == LAST_C) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cpu_reset <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (fill+boot-hold, and no-fill/no-hold) driven
// with randomized streams and compared against an image/checksum model.
module tb_imem_loader;
    localparam int unsigned W     = 16;
    localparam int unsigned AW    = 7;
    localparam int unsigned DEPTH = 128;
    localparam logic [W-1:0] FILL_W = 16'h0000;

    typedef struct {
        int           cyc;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start    [2];
    logic [AW:0]   len      [2];
    logic          abort    [2];
    logic [W-1:0]  in_data  [2];
    logic          in_valid [2];
    logic          in_ready [2];
    logic          i_wr     [2];
    logic [AW-1:0] i_addr   [2];
    logic [W-1:0]  i_data   [2];
    logic          cpu_reset[2];
    logic          busy     [2];
    logic          done     [2];
    logic [W-1:0]  checksum [2];

    imem_loader dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .len(len[0]), .abort(abort[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .I_wr(i_wr[0]), .I_addr(i_addr[0]), .I_data(i_data[0]), .cpu_reset(cpu_reset[0]),
        .busy(busy[0]), .done(done[0]), .checksum(checksum[0])
    );

    imem_loader #(.FILL_EN(1'b0), .FILL_WORD(16'hBEEF), .BOOT_HOLD(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .len(len[1]), .abort(abort[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .I_wr(i_wr[1]), .I_addr(i_addr[1]), .I_data(i_data[1]), .cpu_reset(cpu_reset[1]),
        .busy(busy[1]), .done(done[1]), .checksum(checksum[1])
    );

    int total = 0;
    int bad   = 0;

    // Write/done monitor
    int   cyc = 0;
    wr_t  wq0[$];
    wr_t  wq1[$];
    int   done_cnt[2];
    int   wr_at_done[2];
    logic cpu_at_done[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t r;
        for (int s = 0; s < 2; s++) begin
            if (i_wr[s] === 1'b1) begin
                r.cyc = cyc;
                r.a   = i_addr[s];
                r.d   = i_data[s];
                if (s == 0) wq0.push_back(r);
                else        wq1.push_back(r);
            end
            if (done[s] === 1'b1) begin
                done_cnt[s]++;
                cpu_at_done[s] = cpu_reset[s];
                if (i_wr[s] === 1'b1) wr_at_done[s]++;
            end
        end
    end

    logic [W-1:0] stim[256];
    int   acc;
    bit   tmo;
    bit   busy_drop;
    logic start_cpu;

    task automatic new_stim();
        for (int i = 0; i < 256; i++) stim[i] = W'($urandom);
    endtask

    // Reference: loaded image is stim[0..nd-1] at 0..nd-1, then FILL_W at L..DEPTH-1 when filling.
    function automatic int image_errs(input int sel, input int nd, input bit with_fill, input int l);
        wr_t got[$];
        int n_exp;
        int errs;
        logic [W-1:0] ed;
        if (sel == 0) got = wq0; else got = wq1;
        n_exp = nd + (with_fill ? (DEPTH - l) : 0);
        errs  = (got.size() != n_exp) ? 1 : 0;
        for (int i = 0; i < got.size() && i < n_exp; i++) begin
            ed = (i < nd) ? stim[i] : FILL_W;
            if (got[i].a !== AW'(i) || got[i].d !== ed) errs++;
        end
        return errs;
    endfunction

    function automatic int gaps(input int sel, input int from);
        wr_t got[$];
        int g;
        g = 0;
        if (sel == 0) got = wq0; else got = wq1;
        for (int i = (from < 1) ? 1 : from; i < got.size(); i++)
            if (got[i].cyc != got[i-1].cyc + 1) g++;
        return g;
    endfunction

    function automatic logic [W-1:0] sum_stim(input int n);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + stim[i];
        return s;
    endfunction

    function automatic int n_writes(input int sel);
        return (sel == 0) ? wq0.size() : wq1.size();
    endfunction

    // mode: 0 = valid every cycle, 1 = every other cycle, 2 = random
    task automatic run_load(input int sel, input int len_in, input int nwords, input int mode,
                            input int abort_at, input int mid_start_at);
        int budget;
        bit phase;
        bit ab;
        bit ms_done;
        acc = 0; tmo = 0; busy_drop = 0; phase = 1; ms_done = 0; budget = 3000;
        if (sel == 0) wq0.delete(); else wq1.delete();
        done_cnt[sel] = 0; wr_at_done[sel] = 0;
        @(posedge clk); #1;
        start[sel] = 1'b1;
        len[sel]   = (AW+1)'(len_in);
        @(posedge clk); #1;
        start[sel] = 1'b0;
        start_cpu  = cpu_reset[sel];
        forever begin
            if (budget == 0) begin tmo = 1; break; end
            budget--;
            in_valid[sel] = (acc < nwords) &&
                            (mode == 0 || (mode == 1 && phase) || (mode == 2 && $urandom_range(0, 1) == 1));
            in_data[sel]  = (acc < nwords) ? stim[acc] : '0;
            abort[sel]    = (acc == abort_at);
            if (mid_start_at >= 0 && acc == mid_start_at && !ms_done) begin
                start[sel] = 1'b1;
                len[sel]   = (AW+1)'(1);
                ms_done    = 1;
            end
            phase = !phase;
            @(negedge clk);
            if (busy[sel] !== 1'b1) busy_drop = 1;
            if (in_valid[sel] && in_ready[sel]) acc++;
            ab = abort[sel];
            @(posedge clk); #1;
            start[sel] = 1'b0;
            abort[sel] = 1'b0;
            if (ab || done[sel] === 1'b1) break;
        end
        in_valid[sel] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start[s] = 0; len[s] = '0; abort[s] = 0; in_data[s] = '0; in_valid[s] = 0;
            done_cnt[s] = 0; wr_at_done[s] = 0; cpu_at_done[s] = 1'bx;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if ({i_wr[s], busy[s], done[s], in_ready[s], i_addr[s], i_data[s], checksum[s]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d wr=%b busy=%b done=%b rdy=%b addr=%h data=%h ck=%h expected all zero",
                         s, i_wr[s], busy[s], done[s], in_ready[s], i_addr[s], i_data[s], checksum[s]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_reset[0] !== 1'b1) begin bad++; $display("FAIL boot_hold_dut0 got=%b exp=1", cpu_reset[0]); end
        total++; if (cpu_reset[1] !== 1'b0) begin bad++; $display("FAIL no_boot_hold_dut1 got=%b exp=0", cpu_reset[1]); end
    endtask

    task automatic test_back_to_back();
        stim[0] = 16'h1111; stim[1] = 16'h2222; stim[2] = 16'h3333;
        run_load(1, 3, 3, 0, -1, -1);
        total++; if (tmo) begin bad++; $display("FAIL b2b_timeout got=1 exp=0"); end
        total++; if (start_cpu !== 1'b1) begin bad++; $display("FAIL b2b_cpu_rise got=%b exp=1", start_cpu); end
        total++; if (image_errs(1, 3, 0, 3) != 0) begin bad++; $display("FAIL b2b_image got=%0d errs (%0d writes) exp=0 errs", image_errs(1, 3, 0, 3), n_writes(1)); end
        total++; if (gaps(1, 0) != 0) begin bad++; $display("FAIL b2b_contiguous got=%0d gaps exp=0", gaps(1, 0)); end
        total++; if (checksum[1] !== 16'h6666) begin bad++; $display("FAIL b2b_checksum got=%h exp=6666", checksum[1]); end
        total++; if (done_cnt[1] != 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done_cnt[1]); end
        total++; if (cpu_at_done[1] !== 1'b0 || cpu_reset[1] !== 1'b0) begin bad++; $display("FAIL b2b_cpu_fall got=%b/%b exp=0/0", cpu_at_done[1], cpu_reset[1]); end
        total++; if (busy_drop) begin bad++; $display("FAIL b2b_busy got=drop exp=held"); end
    endtask

    task automatic test_fill_alternating();
        logic [W-1:0] ck;
        new_stim();
        total++; if (cpu_reset[0] !== 1'b1) begin bad++; $display("FAIL fill_boot_hold got=%b exp=1", cpu_reset[0]); end
        run_load(0, 2, 2, 1, -1, -1);
        ck = stim[0] + stim[1];
        total++; if (tmo) begin bad++; $display("FAIL fill_timeout got=1 exp=0"); end
        total++; if (image_errs(0, 2, 1, 2) != 0) begin bad++; $display("FAIL fill_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 2, 1, 2), n_writes(0)); end
        total++; if (wq0.size() >= 2 && wq0[1].cyc - wq0[0].cyc != 2) begin bad++; $display("FAIL fill_data_spacing got=%0d exp=2", wq0[1].cyc - wq0[0].cyc); end
        total++; if (gaps(0, 2) != 0) begin bad++; $display("FAIL fill_contiguous got=%0d gaps exp=0", gaps(0, 2)); end
        total++; if (checksum[0] !== ck) begin bad++; $display("FAIL fill_checksum got=%h exp=%h", checksum[0], ck); end
        total++; if (done_cnt[0] != 1 || wr_at_done[0] != 0) begin bad++; $display("FAIL fill_done got=%0d pulses %0d wr exp=1 pulse 0 wr", done_cnt[0], wr_at_done[0]); end
        total++; if (cpu_reset[0] !== 1'b0) begin bad++; $display("FAIL fill_cpu_release got=%b exp=0", cpu_reset[0]); end
    endtask

    task automatic test_len_zero();
        run_load(0, 0, 0, 0, -1, -1);
        total++; if (image_errs(0, 0, 1, 0) != 0) begin bad++; $display("FAIL len0_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 0, 1, 0), n_writes(0)); end
        total++; if (gaps(0, 0) != 0) begin bad++; $display("FAIL len0_contiguous got=%0d gaps exp=0", gaps(0, 0)); end
        total++; if (checksum[0] !== 16'h0000) begin bad++; $display("FAIL len0_checksum got=%h exp=0000", checksum[0]); end
        total++; if (done_cnt[0] != 1 || tmo) begin bad++; $display("FAIL len0_done got=%0d tmo=%0d exp=1 tmo=0", done_cnt[0], tmo); end
    endtask

    task automatic test_len_clamp();
        new_stim();
        run_load(0, 200, 129, 0, -1, -1);
        total++; if (acc != 128) begin bad++; $display("FAIL clamp_accepted got=%0d exp=128", acc); end
        total++; if (image_errs(0, 128, 0, 128) != 0) begin bad++; $display("FAIL clamp_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 128, 0, 128), n_writes(0)); end
        total++; if (checksum[0] !== sum_stim(128)) begin bad++; $display("FAIL clamp_checksum got=%h exp=%h", checksum[0], sum_stim(128)); end
        total++; if (done_cnt[0] != 1 || tmo) begin bad++; $display("FAIL clamp_done got=%0d tmo=%0d exp=1 tmo=0", done_cnt[0], tmo); end
    endtask

    task automatic test_abort();
        new_stim();
        run_load(0, 10, 10, 0, 5, -1);
        total++; if (acc != 5) begin bad++; $display("FAIL abort_accepted got=%0d exp=5", acc); end
        total++; if (image_errs(0, 5, 0, 5) != 0) begin bad++; $display("FAIL abort_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 5, 0, 5), n_writes(0)); end
        total++; if (done_cnt[0] != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt[0]); end
        total++; if (cpu_reset[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL abort_status got=cpu%b busy%b exp=cpu1 busy0", cpu_reset[0], busy[0]); end
        total++; if (checksum[0] !== sum_stim(5)) begin bad++; $display("FAIL abort_checksum got=%h exp=%h", checksum[0], sum_stim(5)); end
        new_stim();
        run_load(0, 10, 10, 2, -1, -1);
        total++; if (image_errs(0, 10, 1, 10) != 0) begin bad++; $display("FAIL after_abort_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 10, 1, 10), n_writes(0)); end
        total++; if (done_cnt[0] != 1 || cpu_reset[0] !== 1'b0 || tmo) begin bad++; $display("FAIL after_abort_done got=%0d cpu=%b tmo=%0d exp=1 cpu0 tmo0", done_cnt[0], cpu_reset[0], tmo); end
        total++; if (checksum[0] !== sum_stim(10)) begin bad++; $display("FAIL after_abort_checksum got=%h exp=%h", checksum[0], sum_stim(10)); end
    endtask

    task automatic test_start_ignored();
        new_stim();
        run_load(0, 10, 10, 0, -1, 3);
        total++; if (image_errs(0, 10, 1, 10) != 0) begin bad++; $display("FAIL midstart_image got=%0d errs (%0d writes) exp=0 errs", image_errs(0, 10, 1, 10), n_writes(0)); end
        total++; if (done_cnt[0] != 1 || checksum[0] !== sum_stim(10)) begin bad++; $display("FAIL midstart_result got=%0d done ck=%h exp=1 done ck=%h", done_cnt[0], checksum[0], sum_stim(10)); end
    endtask

    task automatic test_random();
        int sel;
        int l_req;
        int l;
        bit fill_on;
        for (int it = 0; it < 6; it++) begin
            new_stim();
            sel     = $urandom_range(0, 1);
            l_req   = $urandom_range(0, 140);
            l       = (l_req > DEPTH) ? DEPTH : l_req;
            fill_on = (sel == 0) && (l < DEPTH);
            run_load(sel, l_req, (l_req > DEPTH) ? DEPTH + 1 : l_req, 2, -1, -1);
            total++; if (acc != l || tmo) begin bad++; $display("FAIL rand%0d_accepted got=%0d tmo=%0d exp=%0d", it, acc, tmo, l); end
            total++; if (image_errs(sel, l, fill_on, l) != 0) begin bad++; $display("FAIL rand%0d_image dut%0d len=%0d got=%0d errs exp=0", it, sel, l_req, image_errs(sel, l, fill_on, l)); end
            total++; if (checksum[sel] !== sum_stim(l)) begin bad++; $display("FAIL rand%0d_checksum got=%h exp=%h", it, checksum[sel], sum_stim(l)); end
            total++; if (done_cnt[sel] != 1 || cpu_reset[sel] !== 1'b0) begin bad++; $display("FAIL rand%0d_done got=%0d cpu=%b exp=1 cpu0", it, done_cnt[sel], cpu_reset[sel]); end
        end
    endtask

    task automatic test_reset_midload();
        int n;
        int budget;
        new_stim();
        wq0.delete();
        n = 0; budget = 50;
        @(posedge clk); #1;
        start[0] = 1'b1; len[0] = (AW+1)'(10);
        @(posedge clk); #1;
        start[0] = 1'b0;
        while (n < 3 && budget > 0) begin
            budget--;
            in_valid[0] = 1'b1; in_data[0] = stim[n];
            @(negedge clk);
            if (in_ready[0]) n++;
            @(posedge clk); #1;
        end
        total++; if (n != 3) begin bad++; $display("FAIL rst_mid_prefix got=%0d words exp=3", n); end
        in_data[0] = stim[3];
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if ({i_wr[0], busy[0], in_ready[0], done[0]} !== 4'b0000 || checksum[0] !== '0) begin bad++; $display("FAIL rst_mid_outputs got=wr%b busy%b rdy%b done%b ck=%h exp=all zero", i_wr[0], busy[0], in_ready[0], done[0], checksum[0]); end
        total++; if (cpu_reset[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_cpu got=%b exp=1", cpu_reset[0]); end
        total++; if (wq0.size() != 3) begin bad++; $display("FAIL rst_mid_writes got=%0d exp=3", wq0.size()); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_alternating();
        test_len_zero();
        test_len_clamp();
        test_abort();
        test_start_ignored();
        test_random();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
